// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vga_timing_pkg : default 640x480@60 timing constants and sync helpers
// | Revision 1.0
// +----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   localparam logic SYNC_INACTIVE  = 1'b1;
   localparam logic VIDEO_INACTIVE = 1'b0;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_bits_t;

   localparam sync_bits_t SYNC_IDLE = '{hsync: SYNC_INACTIVE, vsync: SYNC_INACTIVE,
                                        video_on: VIDEO_INACTIVE};

   // Half-open window test: lo <= v < hi
   function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sync_delay_line : enable-gated shift register, DEPTH 0 is a pass-through
// | Revision 1.0
// +----------------------------------------------------------------------------
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(SYNC_IDLE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign data_o = data_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (shift_en_i) begin
               stage_q[0] <= data_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign data_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vga_sync_gen : pixel-rate enable, row/column counters and delayed syncs
// | Revision 1.0
// +----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = DEF_H_VISIBLE,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_VISIBLE  = DEF_V_VISIBLE,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter int CLK_DIV    = 2,
   parameter int SYNC_DELAY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pixelEn,
   output logic [9:0] pixelColumn,
   output logic [9:0] pixelRow,
   output logic       hsync,
   output logic       vsync,
   output logic       videoOn,
   output logic       frameStart,
   output logic [7:0] frameCount
);

   localparam int         H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int         V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] COL_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] ROW_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

   logic [2:0] div_q, div_d;
   logic       pix_en_q, pix_en_d;
   logic [9:0] col_q, col_d;
   logic [9:0] row_q, row_d;
   logic       frame_start_q, frame_start_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   sync_bits_t raw_q, raw_d;
   sync_bits_t delayed;

   always_comb begin
      div_d       = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
      pix_en_d    = (div_q == DIV_LAST);
      col_d       = col_q;
      row_d       = row_q;
      frame_cnt_d = frame_cnt_q;
      raw_d       = raw_q;
      if (pix_en_q) begin
         if (col_q == COL_LAST) begin
            col_d = 10'd0;
            if (row_q == ROW_LAST) begin
               row_d       = 10'd0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               row_d = row_q + 10'd1;
            end
         end else begin
            col_d = col_q + 10'd1;
         end
         raw_d.hsync    = ~in_window(col_d, HS_START, HS_END);
         raw_d.vsync    = ~in_window(row_d, VS_START, VS_END);
         raw_d.video_on = (col_d < H_VIS) && (row_d < V_VIS);
      end
      // Looks at the post-edge counters so CLK_DIV = 1 (counters moving
      // every clk) flags the same pixel as the slower divisors.
      frame_start_d = pix_en_d && (col_d == COL_LAST) && (row_d == ROW_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= 3'd0;
         pix_en_q      <= 1'b0;
         col_q         <= 10'd0;
         row_q         <= 10'd0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
         raw_q         <= SYNC_IDLE;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         col_q         <= col_d;
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
         raw_q         <= raw_d;
      end
   end

   sync_delay_line #(
      .DEPTH   (SYNC_DELAY),
      .WIDTH   (3),
      .RST_VAL (3'(SYNC_IDLE))
   ) u_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (pix_en_q),
      .data_i     (raw_q),
      .data_o     (delayed)
   );

   assign pixelEn     = pix_en_q;
   assign pixelColumn = col_q;
   assign pixelRow    = row_q;
   assign hsync       = delayed.hsync;
   assign vsync       = delayed.vsync;
   assign videoOn     = delayed.video_on;
   assign frameStart  = frame_start_q;
   assign frameCount  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_vga_sync_gen : directed checks of three vga_sync_gen configurations
// | Revision 1.0
// +----------------------------------------------------------------------------
module tb_vga_sync_gen;

   typedef struct packed {
      logic       en;
      logic [9:0] col;
      logic [9:0] row;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   localparam exp_t RST_EXP = '{en: 1'b0, col: 10'd0, row: 10'd0, hs: 1'b1, vs: 1'b1,
                                vo: 1'b0, fs: 1'b0, fc: 8'd0};

   logic clk = 1'b0;
   logic rst_def = 1'b0;
   logic rst_d0  = 1'b0;
   logic rst_sm  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic       pe_def, hs_def, vs_def, vo_def, fs_def;
   logic [9:0] col_def, row_def;
   logic [7:0] fc_def;
   logic       pe_d0, hs_d0, vs_d0, vo_d0, fs_d0;
   logic [9:0] col_d0, row_d0;
   logic [7:0] fc_d0;
   logic       pe_sm, hs_sm, vs_sm, vo_sm, fs_sm;
   logic [9:0] col_sm, row_sm;
   logic [7:0] fc_sm;
   exp_t       obs_def, obs_d0, obs_sm;

   assign obs_def = {pe_def, col_def, row_def, hs_def, vs_def, vo_def, fs_def, fc_def};
   assign obs_d0  = {pe_d0, col_d0, row_d0, hs_d0, vs_d0, vo_d0, fs_d0, fc_d0};
   assign obs_sm  = {pe_sm, col_sm, row_sm, hs_sm, vs_sm, vo_sm, fs_sm, fc_sm};

   // Defaults: 800x525, CLK_DIV 2, SYNC_DELAY 2
   vga_sync_gen u_def (
      .clk(clk), .rst_n(rst_def), .pixelEn(pe_def), .pixelColumn(col_def),
      .pixelRow(row_def), .hsync(hs_def), .vsync(vs_def), .videoOn(vo_def),
      .frameStart(fs_def), .frameCount(fc_def));

   // Full line timing, 8-line frame (vsync rows 5..6), no sync delay
   vga_sync_gen #(
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(0)
   ) u_d0 (
      .clk(clk), .rst_n(rst_d0), .pixelEn(pe_d0), .pixelColumn(col_d0),
      .pixelRow(row_d0), .hsync(hs_d0), .vsync(vs_d0), .videoOn(vo_d0),
      .frameStart(fs_d0), .frameCount(fc_d0));

   // 10x4 frame at one clk per pixel: hsync cols 7..8, vsync row 2
   vga_sync_gen #(
      .H_VISIBLE(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .CLK_DIV(1), .SYNC_DELAY(0)
   ) u_sm (
      .clk(clk), .rst_n(rst_sm), .pixelEn(pe_sm), .pixelColumn(col_sm),
      .pixelRow(row_sm), .hsync(hs_sm), .vsync(vs_sm), .videoOn(vo_sm),
      .frameStart(fs_sm), .frameCount(fc_sm));

   // Closed-form expectation k clock edges after reset release.
   // n = completed pixel advances; delayed outputs show the decode of the
   // counter state n-sd, inactive while that state predates the first advance.
   function automatic exp_t model(input int k, input int d, input int hv, input int hf,
                                  input int hs, input int hb, input int vv, input int vf,
                                  input int vs, input int vb, input int sd);
      exp_t e;
      int   ht, vt, n, m, c, r;
      ht    = hv + hf + hs + hb;
      vt    = vv + vf + vs + vb;
      n     = (k >= 1) ? (k - 1) / d : 0;
      e.en  = (k >= 1) && (k % d == 0);
      e.col = 10'(n % ht);
      e.row = 10'((n / ht) % vt);
      e.fc  = 8'((n / (ht * vt)) % 256);
      e.fs  = e.en && (n % (ht * vt) == ht * vt - 1);
      m     = n - sd;
      if (m <= 0) begin
         e.hs = 1'b1;
         e.vs = 1'b1;
         e.vo = 1'b0;
      end else begin
         c    = m % ht;
         r    = (m / ht) % vt;
         e.hs = !((c >= hv + hf) && (c < hv + hf + hs));
         e.vs = !((r >= vv + vf) && (r < vv + vf + vs));
         e.vo = (c < hv) && (r < vv);
      end
      return e;
   endfunction

   int k_def;

   task automatic test_reset();
      rst_def = 1'b0;
      rst_d0  = 1'b0;
      rst_sm  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs_def !== RST_EXP) begin
         errors++;
         $display("FAIL reset_def: got %h expected %h", obs_def, RST_EXP);
      end
      checks++;
      if (obs_d0 !== RST_EXP) begin
         errors++;
         $display("FAIL reset_d0: got %h expected %h", obs_d0, RST_EXP);
      end
      checks++;
      if (obs_sm !== RST_EXP) begin
         errors++;
         $display("FAIL reset_sm: got %h expected %h", obs_sm, RST_EXP);
      end
   endtask

   task automatic test_first_line();
      exp_t e;
      rst_def = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         @(negedge clk);
         k_def = k;
         e = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 2);
         checks++;
         if (obs_def !== e) begin
            errors++;
            $display("FAIL first_line k=%0d: got %h expected %h", k, obs_def, e);
         end
         if (k == 1 || k == 2) begin
            checks++;
            if (pe_def !== (k == 2)) begin
               errors++;
               $display("FAIL first_pixel_en k=%0d: got %b expected %b", k, pe_def, k == 2);
            end
         end
         if (k == 1600) begin
            checks++;
            if (col_def !== 10'd799 || row_def !== 10'd0) begin
               errors++;
               $display("FAIL last_col: got row %0d col %0d expected row 0 col 799",
                        row_def, col_def);
            end
         end
         if (k == 1601) begin
            checks++;
            if (col_def !== 10'd0 || row_def !== 10'd1) begin
               errors++;
               $display("FAIL line_wrap: got row %0d col %0d expected row 1 col 0",
                        row_def, col_def);
            end
         end
      end
   endtask

   task automatic test_sync_delay();
      exp_t e;
      for (int k = k_def + 1; k <= 3300; k++) begin
         @(negedge clk);
         e = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 2);
         checks++;
         if (obs_def !== e) begin
            errors++;
            $display("FAIL delay_line k=%0d: got %h expected %h", k, obs_def, e);
         end
         // row 1: col 656 at k=2913, hsync falls 4 clks later
         if (k == 2913) begin
            checks++;
            if (col_def !== 10'd656 || hs_def !== 1'b1) begin
               errors++;
               $display("FAIL hs_delay_start: got col %0d hs %b expected col 656 hs 1",
                        col_def, hs_def);
            end
         end
         if (k == 2916 || k == 2917) begin
            checks++;
            if (hs_def !== (k == 2916)) begin
               errors++;
               $display("FAIL hs_delay_edge k=%0d: got %b expected %b", k, hs_def, k == 2916);
            end
         end
         // col 640 at k=2881, videoOn falls at k=2885
         if (k == 2884 || k == 2885) begin
            checks++;
            if (vo_def !== (k == 2884)) begin
               errors++;
               $display("FAIL vo_delay_edge k=%0d: got %b expected %b", k, vo_def, k == 2884);
            end
         end
      end
   endtask

   task automatic test_frame_timing();
      exp_t e;
      int   hs_low, vs_low, vo_high, fs_cnt, fs_first, fs_second;
      hs_low = 0; vs_low = 0; vo_high = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
      @(negedge clk);
      rst_d0 = 1'b1;
      for (int k = 1; k <= 25700; k++) begin
         @(negedge clk);
         e = model(k, 2, 640, 16, 96, 48, 4, 1, 2, 1, 0);
         checks++;
         if (obs_d0 !== e) begin
            errors++;
            $display("FAIL frame_timing k=%0d: got %h expected %h", k, obs_d0, e);
         end
         if (k >= 1601 && k <= 3200 && hs_d0 === 1'b0) hs_low++;
         if (k >= 3 && k <= 12802) begin
            if (vs_d0 === 1'b0) vs_low++;
            if (vo_d0 === 1'b1) vo_high++;
         end
         if (fs_d0 === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
      end
      checks++;
      if (hs_low != 192) begin
         errors++;
         $display("FAIL hsync_width: got %0d clks expected 192", hs_low);
      end
      checks++;
      if (vs_low != 3200) begin
         errors++;
         $display("FAIL vsync_width: got %0d clks expected 3200", vs_low);
      end
      checks++;
      if (vo_high != 5120) begin
         errors++;
         $display("FAIL video_on_area: got %0d clks expected 5120", vo_high);
      end
      checks++;
      if (fs_cnt != 2 || fs_first != 12800 || fs_second != 25600) begin
         errors++;
         $display("FAIL frame_start: got %0d pulses at %0d,%0d expected 2 at 12800,25600",
                  fs_cnt, fs_first, fs_second);
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      rst_d0 = 1'b0;
      @(negedge clk);
      rst_d0 = 1'b1;
      for (int k = 1; k <= 8802; k++) @(negedge clk);
      checks++;
      if (row_d0 !== 10'd5 || col_d0 !== 10'd400) begin
         errors++;
         $display("FAIL mid_frame_pos: got row %0d col %0d expected row 5 col 400",
                  row_d0, col_d0);
      end
      #2 rst_d0 = 1'b0;
      #1;
      checks++;
      if (obs_d0 !== RST_EXP) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs_d0, RST_EXP);
      end
      @(negedge clk);
      checks++;
      if (obs_d0 !== RST_EXP) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", obs_d0, RST_EXP);
      end
      rst_d0 = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         @(negedge clk);
         e = model(k, 2, 640, 16, 96, 48, 4, 1, 2, 1, 0);
         checks++;
         if (obs_d0 !== e) begin
            errors++;
            $display("FAIL restart k=%0d: got %h expected %h", k, obs_d0, e);
         end
      end
   endtask

   task automatic test_clkdiv1_wrap();
      exp_t e;
      @(negedge clk);
      rst_sm = 1'b1;
      for (int k = 1; k <= 10300; k++) begin
         @(negedge clk);
         e = model(k, 1, 6, 1, 2, 1, 1, 1, 1, 1, 0);
         checks++;
         if (obs_sm !== e) begin
            errors++;
            $display("FAIL clkdiv1 k=%0d: got %h expected %h", k, obs_sm, e);
         end
         // 256 frames of 40 pixels complete on edge 10241
         if (k == 10240 || k == 10241) begin
            checks++;
            if (fc_sm !== ((k == 10240) ? 8'd255 : 8'd0)) begin
               errors++;
               $display("FAIL frame_count_wrap k=%0d: got %0d expected %0d", k, fc_sm,
                        (k == 10240) ? 255 : 0);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_sync_delay();
      test_frame_timing();
      test_reset_mid_frame();
      test_clkdiv1_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage of the text-mode video path.
- Generates 640x480@60 Hz VGA timing from the system clock: pixel-rate enable, active-low hsync/vsync, videoOn, and the pixelRow/pixelColumn counters.
- pixelRow/pixelColumn feed the character-address generator directly.
- hsync/vsync/videoOn are delayed by a configurable number of pixel periods, matching the latency of the char-ROM and serializer pipeline downstream.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (legal 1..8)
- SYNC_DELAY, 2, pixel periods of delay on hsync/vsync/videoOn relative to the counters (legal 0..4)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- pixelEn  out  1  one-clk pulse per pixel period
- pixelColumn  out  10  horizontal count, 0..H_TOTAL-1
- pixelRow  out  10  vertical count, 0..V_TOTAL-1
- hsync  out  1  active-low horizontal sync, delayed
- vsync  out  1  active-low vertical sync, delayed
- videoOn  out  1  high in visible region, delayed
- frameStart  out  1  one-clk pulse when counters wrap to (0,0)
- frameCount  out  8  frame counter, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Assertion clears all state immediately, including mid-line and mid-frame.
- Reset values:
  - divider, pixelColumn, pixelRow, frameCount = 0
  - pixelEn = 0, frameStart = 0, videoOn = 0
  - hsync = 1, vsync = 1
  - every delay-pipeline stage holds its inactive value (hsync/vsync 1, videoOn 0).
- Totals: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be <= 1024. Counters are 10-bit.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixelEn is registered and high for the clk after divider == CLK_DIV-1.
  - The first pixelEn is high on clock edge CLK_DIV after reset release.
  - With CLK_DIV = 1, pixelEn is high every clk after the first edge.
- Counters (advance only on cycles with pixelEn = 1):
  - pixelColumn increments. At H_TOTAL-1 it wraps to 0 and pixelRow increments.
  - pixelRow wraps V_TOTAL-1 -> 0 in the same tick that pixelColumn wraps.
  - pixelRow/pixelColumn are the counter registers themselves: zero latency to the downstream address generator.
- Raw decode, computed from the next counter values so it is registered and aligned with the counters:
  - hsync_raw = 0 iff H_VISIBLE+H_FRONT <= col < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vsync_raw = 0 iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (490..491)
  - videoOn_raw = (col < H_VISIBLE) && (row < V_VISIBLE)
- Delay line:
  - Raw signals pass through SYNC_DELAY stages that shift only on pixelEn.
  - Outputs therefore lag the counters by exactly SYNC_DELAY pixel periods.
  - SYNC_DELAY = 0 gives direct registered outputs.
- frameStart: high for the same clk as the pixelEn that moves the counters from (V_TOTAL-1, H_TOTAL-1) to (0,0).
- frameCount: increments on that same pulse; 255 wraps to 0.
- Frame length: H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).
- Outputs never change except on a pixelEn cycle or on reset.

Decomposition:
- Package vga_timing_pkg:
  - default timing localparams (H_*/V_* for 640x480)
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - inactive-level constants for sync polarity
- Sub-module sync_delay_line:
  - parameterised depth and width, shift-enable input, reset-to-constant value
  - instantiated once, 3 bits wide, for {hsync, vsync, videoOn}.

Test Plan:
- Reset release, defaults: first pixelEn at edge 2. pixelColumn reaches 799 then 0. pixelRow increments 0->1 on that same pixelEn.
- Line timing, SYNC_DELAY=0: hsync low exactly while pixelColumn in 656..751 (96 pixels, 192 clks). videoOn high for columns 0..639 of rows 0..479 only.
- Frame timing: vsync low for rows 490..491 (1600 pixels). frameStart pulses every 840000 clks. frameCount 255 -> 0 after 256 frames (force via reduced V/H params).
- SYNC_DELAY=2: hsync falls 2 pixel periods (4 clks) after pixelColumn reaches 656. videoOn falls 2 pixel periods after column 640.
- Reset mid-frame: assert rst_n low at row 300, column 400, between clock edges. All outputs take reset values immediately, without a clock edge. Restart is identical to the first scenario.
- CLK_DIV=1 with reduced timing (H_TOTAL=10, V_TOTAL=4): pixelEn constantly high after reset. Wraps, sync windows and frameStart checked against the formulas every cycle.
